// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and iterative shift-add multiplier
`timescale 1ns/1ps

module alu_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] CNT_LAST = LW'(N - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t state, state_nxt;

  logic          xfer;
  logic          is_mul;
  logic [LW-1:0] shamt;
  logic [N:0]    add_w, sub_w, lsl_w, lsr_w;
  logic [N-1:0]  alu_res;
  logic          alu_c, alu_v;

  logic [N-1:0]   mcand;
  logic [2*N-1:0] prod, prod_nxt;
  logic [N:0]     mul_sum;
  logic [LW-1:0]  cnt;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign xfer      = in_valid && in_ready;
  assign is_mul    = (ALUControl == OP_MUL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = is_mul ? MUL : HOLD;
      MUL:     if (cnt == CNT_LAST) state_nxt = HOLD;
      HOLD: begin
        if (xfer)           state_nxt = is_mul ? MUL : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Widened shifts expose the last bit shifted out at the extra position.
  assign shamt = b[LW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
  assign lsl_w = {1'b0, a} << shamt;
  assign lsr_w = {a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = add_w[N-1:0];
        alu_c   = add_w[N];
        alu_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[N-1:0];
        alu_c   = sub_w[N];
        alu_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      OP_PASS: alu_res = b;
      OP_NOR:  alu_res = ~(a | b);
      OP_LSL: begin
        alu_res = lsl_w[N-1:0];
        alu_c   = lsl_w[N];
      end
      OP_LSR: begin
        alu_res = lsr_w[N:1];
        alu_c   = lsr_w[0];
      end
      default: alu_res = '0;
    endcase
  end

  // prod holds {partial sum, remaining multiplier bits}; one multiplier bit retires per cycle.
  assign mul_sum  = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : {(N+1){1'b0}});
  assign prod_nxt = {mul_sum, prod[N-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else if (xfer) begin
      if (is_mul) begin
        mcand <= a;
        prod  <= {{N{1'b0}}, b};
        cnt   <= '0;
      end else begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        negative <= alu_res[N-1];
        carry    <= alu_c;
        overflow <= alu_v;
      end
    end else if (state == MUL) begin
      prod <= prod_nxt;
      cnt  <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        result   <= prod_nxt[N-1:0];
        zero     <= (prod_nxt[N-1:0] == '0);
        negative <= prod_nxt[N-1];
        carry    <= |prod_nxt[2*N-1:N];
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector table, handshake sequences and randomized model check for alu_seq
`timescale 1ns/1ps

module tb_alu_seq;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   ALUControl = 4'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         zero, negative, carry, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    int          hold;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results from wide integer arithmetic, overflow from signed range.
  task automatic model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic c, output logic v);
    logic [64:0]        s;
    logic signed [64:0] ws;
    logic [127:0]       p;
    logic [63:0]        t;
    int                 sh;
    r = '0; c = 1'b0; v = 1'b0;
    sh = int'(y[5:0]);
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y}; r = s[63:0]; c = s[64];
        ws = $signed({x[63], x}) + $signed({y[63], y}); v = ws[64] ^ ws[63];
      end
      4'b0110: begin
        r = x - y; c = (x >= y);
        ws = $signed({x[63], x}) - $signed({y[63], y}); v = ws[64] ^ ws[63];
      end
      4'b0111: r = y;
      4'b1100: r = ~(x | y);
      4'b1000: begin
        p = {64'd0, x} * {64'd0, y}; r = p[63:0]; c = |p[127:64];
      end
      4'b1001: begin
        r = x << sh;
        if (sh != 0) begin t = x >> (64 - sh); c = t[0]; end
      end
      4'b1010: begin
        r = x >> sh;
        if (sh != 0) begin t = x >> (sh - 1); c = t[0]; end
      end
      default: r = '0;
    endcase
  endtask

  // Called at posedge+1 with the DUT idle; leaves it idle at posedge+1.
  task automatic exec(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y, input int hold,
                      input logic [63:0] er, input logic [3:0] ef, input string tag);
    int          lat;
    int          exp_lat;
    bit          bad;
    logic [63:0] r0;
    exp_lat = (op == 4'b1000) ? N : 0;
    in_valid = 1'b1; ALUControl = op; a = x; b = y; out_ready = (hold == 0);
    @(negedge clk);
    chk($sformatf("%s in_ready", tag), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; ALUControl = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 0; bad = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
    if (exp_lat != 0) chk($sformatf("%s busy_in_ready", tag), 64'(bad), 64'd0);
    @(negedge clk);
    chk($sformatf("%s result", tag), result, er);
    chk($sformatf("%s flags_zncv", tag), 64'({zero, negative, carry, overflow}), 64'(ef));
    if (hold > 0) begin
      bad = 0; r0 = result;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || result !== r0 || in_ready !== 1'b0) bad = 1;
      end
      chk($sformatf("%s stall_stable", tag), 64'(bad), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("%s drained", tag), 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] x, y, er;
    logic        ec, ev;
    bit          bad;

    vecs[0]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 4'b1010};
    vecs[1]  = '{4'b0010, 64'd23, 64'd8, 0, 64'd31, 4'b0000};
    vecs[2]  = '{4'b0110, 64'd23, 64'd3, 0, 64'd20, 4'b0010};
    vecs[3]  = '{4'b0110, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[4]  = '{4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 4'b0101};
    vecs[5]  = '{4'b1000, 64'd23, 64'd3, 0, 64'd69, 4'b0000};
    vecs[6]  = '{4'b1000, 64'h1_0000_0000, 64'h1_0000_0000, 0, 64'd0, 4'b1010};
    vecs[7]  = '{4'b1001, 64'd1, 64'd63, 0, 64'h8000_0000_0000_0000, 4'b0100};
    vecs[8]  = '{4'b1010, 64'd10, 64'd1, 0, 64'd5, 4'b0000};
    vecs[9]  = '{4'b1100, 64'd10, 64'd15, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0100};
    vecs[10] = '{4'b1111, 64'd5, 64'd9, 0, 64'd0, 4'b1000};
    vecs[11] = '{4'b0111, 64'hFF, 64'h1234, 0, 64'h1234, 4'b0000};
    vecs[12] = '{4'b1010, 64'd3, 64'd1, 0, 64'd1, 4'b0010};
    vecs[13] = '{4'b1001, 64'h8000_0000_0000_0001, 64'd64, 0, 64'h8000_0000_0000_0001, 4'b0100};
    vecs[14] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'd1, 4'b0010};
    vecs[15] = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 4'b0101};
    vecs[16] = '{4'b0001, 64'hF0, 64'h0F, 2, 64'hFF, 4'b0000};

    // Reset with a request pending: nothing may be taken or presented.
    #1 reset = 1'b0;
    in_valid = 1'b1; ALUControl = 4'b0010; a = 64'd5; b = 64'd6;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst flags", 64'({zero, negative, carry, overflow}), 64'd0);
    reset = 1'b1; in_valid = 1'b0;
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 17; i++)
      exec(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].hold, vecs[i].r, vecs[i].f, $sformatf("vec%0d", i));

    // Backpressure followed by a back-to-back transfer out of HOLD.
    in_valid = 1'b1; ALUControl = 4'b0000; a = 64'hF0F0; b = 64'hCEC1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    chk("bp and out_valid", 64'(out_valid), 64'd1);
    chk("bp and result", result, 64'hC0C0);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 64'hC0C0 || in_ready !== 1'b0) bad = 1;
    end
    chk("bp stall", 64'(bad), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = 4'b0001; a = 64'hC0C0; b = 64'hC0CA;
    #1 chk("bp in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp or out_valid", 64'(out_valid), 64'd1);
    chk("bp or result", result, 64'hC0CA);
    @(posedge clk); #1;
    chk("bp drained", 64'(out_valid), 64'd0);

    // Reset in the 10th cycle of a multiply discards it.
    in_valid = 1'b1; ALUControl = 4'b1000; a = 64'd5; b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mulrst out_valid", 64'(out_valid), 64'd0);
    chk("mulrst result", result, 64'd0);
    chk("mulrst flags", 64'({zero, negative, carry, overflow}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("mulrst in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (N + 5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1;
    end
    chk("mulrst no_stale", 64'(bad), 64'd0);
    exec(4'b0010, 64'd1, 64'd1, 0, 64'd2, 4'b0000, "mulrst add");

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin x = 64'($urandom_range(0, 255)); y = 64'($urandom_range(0, 255)); end
        1: begin x = {$urandom, $urandom} | 64'h8000_0000_0000_0000; y = 64'($urandom_range(0, 3)); end
        default: begin x = {$urandom, $urandom}; y = {$urandom, $urandom}; end
      endcase
      model(op, x, y, er, ec, ev);
      exec(op, x, y, $urandom_range(0, 2), er, {er == 64'd0, er[63], ec, ev}, $sformatf("rnd%0d op%b", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 64: operand/result width; power of two, N >= 8.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low: 0 = reset.
REQ-004 in_valid  in  1  operation request.
REQ-005 in_ready  out  1  block can accept a request this cycle.
REQ-006 a  in  N  first operand.
REQ-007 b  in  N  second operand; low log2(N) bits give the shift amount for shift ops.
REQ-008 ALUControl  in  4  operation code.
REQ-009 out_valid  out  1  result and flags valid.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 result  out  N  operation result.
REQ-012 zero  out  1  result == 0.
REQ-013 negative  out  1  result[N-1].
REQ-014 carry  out  1  carry/borrow/shift-out flag.
REQ-015 overflow  out  1  signed overflow flag.

Function
REQ-016 A transfer occurs on a rising edge with in_valid=1 and in_ready=1; a, b and ALUControl are captured then, and later input changes are ignored.
REQ-017 Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 pass b; 1100 NOR; 1000 MUL; 1001 LSL (a << b[log2N-1:0]); 1010 LSR (logical, a >> b[log2N-1:0]); every other code gives result 0.
REQ-018 FSM states: IDLE, MUL, HOLD.
REQ-019 IDLE -> HOLD on a transfer of any non-MUL op; IDLE -> MUL on a transfer of MUL.
REQ-020 MUL is an iterative shift-add over N cycles; MUL -> HOLD when the iteration counter completes.
REQ-021 In MUL, out_valid rises exactly N rising edges after the transfer edge.
REQ-022 Non-MUL ops have latency 1: out_valid=1 in the cycle after the transfer edge.
REQ-023 out_valid=1 only in HOLD; result and flags remain stable in HOLD until an edge with out_ready=1.
REQ-024 in_ready=1 in IDLE; in_ready=1 in HOLD when out_ready=1; in_ready=0 in MUL.
REQ-025 HOLD with out_ready=1 and no transfer -> IDLE, out_valid=0.
REQ-026 HOLD with out_ready=1 and a transfer -> next state per REQ-019, giving back-to-back operation with no bubble for non-MUL ops.
REQ-027 zero and negative follow REQ-012/013 for every op, including MUL, shift and undefined codes.
REQ-028 ADD: carry = carry out of bit N-1; overflow = operand signs equal and result sign differs.
REQ-029 SUB: computed as a + ~b + 1; carry = carry out (1 = no borrow); overflow = operand signs differ and result sign differs from a.
REQ-030 MUL: result = low N bits of the unsigned 2N-bit product; carry = OR of the high N bits; overflow = 0.
REQ-031 LSL/LSR: carry = last bit shifted out, or 0 when the shift amount is 0; overflow = 0.
REQ-032 AND, OR, NOR, pass b and undefined codes: carry = 0, overflow = 0.

Reset
REQ-033 reset=0 immediately forces state IDLE, out_valid=0, result=0, zero=0, negative=0, carry=0, overflow=0, and clears the MUL counter and accumulator, independent of clk.
REQ-034 reset=0 during MUL or HOLD aborts the operation; the pending result is discarded and is never presented.
REQ-035 No transfer is taken while reset=0; the first transfer can occur on the first rising edge after release, with in_ready=1.

Verification (N=64)
REQ-036 ADD a=FFFF_FFFF_FFFF_FFFF, b=1 -> next cycle: out_valid=1, result=0, zero=1, carry=1, overflow=0; ADD 23+8 -> 31, flags 0.
REQ-037 SUB 23-3 -> 20, carry=1; SUB 0-1 -> FFFF_FFFF_FFFF_FFFF, negative=1, carry=0; SUB 7FFF_FFFF_FFFF_FFFF-(FFFF_FFFF_FFFF_FFFF) -> 8000_0000_0000_0000, overflow=1, negative=1.
REQ-038 MUL 23*3 -> 69, out_valid exactly 64 edges after transfer, in_ready=0 throughout; MUL 2^32*2^32 -> result 0, zero=1, carry=1.
REQ-039 Backpressure: AND F0F0 & CEC1 -> C0C0; hold out_ready=0 for 5 cycles -> result stable, out_valid=1, in_ready=0; then out_ready=1 with in_valid=1 (OR C0C0|C0CA) -> C0CA presented the following cycle, no bubble.
REQ-040 reset=0 on the 10th cycle of a MUL -> out_valid=0 and result=0 immediately; after release, ADD 1+1 -> 2 with latency 1 and no stale MUL result.
REQ-041 Shift and default codes: LSL 1 by 63 -> 8000_0000_0000_0000, negative=1; LSR 1010b by 1 -> 5, carry=0; NOR 1010b,1111b -> FFFF_FFFF_FFFF_FFF0; code 1111 -> result 0, zero=1.
